// File: rtl/bus_pkg.sv
// Shared definitions for bus endpoints: ID field width, broadcast ID and
// destination extraction from a packet.
package bus_pkg;
   localparam int ID_W = 8;
   localparam logic [ID_W-1:0] BROADCAST_ID = {ID_W{1'b1}};
   // Widest packet dest_of accepts; callers zero-extend into this width.
   localparam int PKT_MAX = 64;

   function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX-1:0] pkt,
                                               input int pkt_w);
      return ID_W'(pkt >> (pkt_w - ID_W));
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO with occupancy count and a
// sticky overflow flag. A write into a full FIFO is accepted only with a read.
module sync_fifo #(
   parameter int width = 16,
   parameter int depth = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr,
   input  logic [width-1:0]       wdata,
   input  logic                   rd,
   output logic [width-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(depth):0] count,
   output logic                   ovf
);
   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;

   logic [width-1:0] mem [depth];
   logic [AW-1:0]    wptr, rptr;
   logic             wr_ok, rd_ok;

   assign full  = (count == CW'(depth));
   assign empty = (count == '0);
   assign rd_ok = rd && !empty;
   assign wr_ok = wr && (!full || rd);

   // Masked when empty so the head reads zero after reset and after draining.
   assign rdata = empty ? '0 : mem[rptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (wr_ok) wptr <= wptr + AW'(1);
         if (rd_ok) rptr <= rptr + AW'(1);
         count <= count + CW'(wr_ok) - CW'(rd_ok);
         if (wr && full && !rd) ovf <= 1'b1;
      end
   end

   // NOTE: storage has no reset; validity is tracked by count, and leaving
   // the array unreset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr] <= wdata;
   end
endmodule

// File: rtl/bus_port_fifo.sv
// Per-device bus endpoint: TX queue toward the arbiter, ID-filtered RX queue
// from it, plus drop counting and protocol error flags.
module bus_port_fifo
   import bus_pkg::*;
#(
   parameter int             pckg_sz   = 16,
   parameter int             depth     = 8,
   parameter logic [ID_W-1:0] id       = '0,
   parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [pckg_sz-1:0] wr_data,
   output logic               tx_full,
   output logic               pndng,
   output logic [pckg_sz-1:0] D_pop,
   input  logic               pop,
   input  logic               push,
   input  logic [pckg_sz-1:0] D_push,
   output logic               rx_valid,
   output logic [pckg_sz-1:0] rx_data,
   input  logic               rx_rd,
   output logic               tx_ovf,
   output logic               rx_ovf,
   output logic               pop_err,
   output logic [7:0]         rx_drop_cnt
);
   logic                   tx_empty, rx_empty, rx_full;
   logic [$clog2(depth):0] tx_count, rx_count;
   logic [ID_W-1:0]        dest;
   logic                   eligible;
   logic                   unused_status;

   sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
      .clk   (clk),
      .reset (reset),
      .wr    (wr_en),
      .wdata (wr_data),
      .rd    (pop),
      .rdata (D_pop),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count),
      .ovf   (tx_ovf)
   );

   assign pndng = !tx_empty;

   assign dest     = dest_of(PKT_MAX'(D_push), pckg_sz);
   assign eligible = (dest == id) || (dest == broadcast);

   sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
      .clk   (clk),
      .reset (reset),
      .wr    (push && eligible),
      .wdata (D_push),
      .rd    (rx_rd),
      .rdata (rx_data),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count),
      .ovf   (rx_ovf)
   );

   assign rx_valid = !rx_empty;

   // Occupancy detail is not exported at this level.
   assign unused_status = ^{tx_count, rx_count, rx_full};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pop_err     <= 1'b0;
         rx_drop_cnt <= '0;
      end else begin
         if (pop && tx_empty) pop_err <= 1'b1;
         if (push && !eligible && rx_drop_cnt != 8'hFF)
            rx_drop_cnt <= rx_drop_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed bench for bus_port_fifo (id=2, depth=8): TX ordering, full/overflow,
// pop errors, async reset, RX filtering, RX full handling and drop saturation.
module tb_bus_port_fifo;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wr_en = 1'b0, pop = 1'b0, push = 1'b0, rx_rd = 1'b0;
   logic [15:0] wr_data = '0, D_push = '0;
   logic        tx_full, pndng, rx_valid, tx_ovf, rx_ovf, pop_err;
   logic [15:0] D_pop, rx_data;
   logic [7:0]  rx_drop_cnt;

   int checks = 0;
   int errors = 0;

   bus_port_fifo #(.pckg_sz(16), .depth(8), .id(8'h02)) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .tx_full     (tx_full),
      .pndng       (pndng),
      .D_pop       (D_pop),
      .pop         (pop),
      .push        (push),
      .D_push      (D_push),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_rd       (rx_rd),
      .tx_ovf      (tx_ovf),
      .rx_ovf      (rx_ovf),
      .pop_err     (pop_err),
      .rx_drop_cnt (rx_drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs are applied and outputs sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_pndng", pndng, 0);
      check("rst_tx_full", tx_full, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_D_pop", D_pop, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_flags", {tx_ovf, rx_ovf, pop_err}, 0);
      check("rst_drop_cnt", rx_drop_cnt, 0);
      do_reset();

      // Single write, one-cycle latency, then pop
      wr_en = 1; wr_data = 16'h0155;
      check("no_bypass_pndng", pndng, 0);
      tick();
      wr_en = 0;
      check("wr1_pndng", pndng, 1);
      check("wr1_D_pop", D_pop, 16'h0155);
      pop = 1;
      tick();
      pop = 0;
      check("pop1_pndng", pndng, 0);
      check("pop1_pop_err", pop_err, 0);

      // Fill to full, overflow, drain across pointer wrap
      for (int i = 0; i < 8; i++) begin
         wr_en = 1; wr_data = 16'h0100 + 16'(i);
         tick();
      end
      check("fill_tx_full", tx_full, 1);
      check("fill_tx_ovf", tx_ovf, 0);
      wr_data = 16'h0108;
      tick();
      wr_en = 0;
      check("ovf_tx_ovf", tx_ovf, 1);
      check("ovf_tx_full", tx_full, 1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_%0d", i), D_pop, 16'h0100 + 16'(i));
         pop = 1;
         tick();
      end
      pop = 0;
      check("drain_pndng", pndng, 0);
      check("drain_tx_full", tx_full, 0);

      // Full TX with simultaneous write and pop
      do_reset();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1; wr_data = 16'h0200 + 16'(i);
         tick();
      end
      wr_data = 16'h0208; pop = 1;
      tick();
      wr_en = 0; pop = 0;
      check("wrpop_tx_full", tx_full, 1);
      check("wrpop_tx_ovf", tx_ovf, 0);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("wrpop_drain_%0d", i), D_pop, 16'h0200 + 16'(i));
         pop = 1;
         tick();
      end
      pop = 0;
      check("wrpop_empty", pndng, 0);
      check("wrpop_pop_err", pop_err, 0);

      // Pop while empty, then write+pop while empty
      pop = 1;
      tick();
      pop = 0;
      check("empty_pop_err", pop_err, 1);
      check("empty_pndng", pndng, 0);
      wr_en = 1; wr_data = 16'h0300; pop = 1;
      tick();
      pop = 0;
      check("wr_pop_empty_pndng", pndng, 1);
      check("wr_pop_empty_D_pop", D_pop, 16'h0300);
      for (int i = 1; i < 5; i++) begin
         wr_data = 16'h0300 + 16'(i);
         tick();
      end
      wr_en = 0;
      check("burst_head", D_pop, 16'h0300);

      // Asynchronous reset mid-burst, checked before the next clock edge
      #2;
      reset = 0;
      #1;
      check("async_pndng", pndng, 0);
      check("async_pop_err", pop_err, 0);
      check("async_D_pop", D_pop, 0);
      tick();
      reset = 1;

      // RX filter: own ID, broadcast, foreign
      push = 1; D_push = 16'h0211; tick();
      D_push = 16'hFF22; tick();
      D_push = 16'h0333; tick();
      push = 0;
      check("rx_valid", rx_valid, 1);
      check("rx_head0", rx_data, 16'h0211);
      check("rx_drop1", rx_drop_cnt, 1);
      rx_rd = 1; tick();
      check("rx_head1", rx_data, 16'hFF22);
      tick();
      check("rx_empty_valid", rx_valid, 0);
      check("rx_empty_data", rx_data, 0);
      tick();
      rx_rd = 0;
      check("rx_rd_empty_ovf", rx_ovf, 0);
      check("rx_rd_empty_valid", rx_valid, 0);

      // RX full: drop without read, accept with read
      push = 1;
      for (int i = 0; i < 8; i++) begin
         D_push = 16'h0240 + 16'(i);
         tick();
      end
      D_push = 16'h0248; tick();
      check("rx_full_ovf", rx_ovf, 1);
      D_push = 16'h0249; rx_rd = 1; tick();
      push = 0; rx_rd = 0;
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("rx_full_drain_%0d", i), rx_data,
               (i == 8) ? 32'h0249 : 32'h0240 + 32'(i));
         rx_rd = 1;
         tick();
      end
      rx_rd = 0;
      check("rx_full_drained", rx_valid, 0);
      check("rx_full_drop_cnt", rx_drop_cnt, 1);

      // Drop counter saturation
      push = 1; D_push = 16'h0533;
      for (int i = 0; i < 253; i++) tick();
      check("drop_254", rx_drop_cnt, 254);
      for (int i = 0; i < 47; i++) tick();
      push = 0;
      check("drop_sat", rx_drop_cnt, 255);
      check("drop_not_stored", rx_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
